ps2_player_input: RTL and testbench

//  Parametrised PS/2 scancode decoder for 2..MAX_PLAYERS Tron players.
//  - Tracks E0 (extended) and F0 (break) prefixes.
//  - Maps make codes to per-player direction requests.
//  - Buffers each player's requests in a small queue, so two quick turns between game ticks are not lost.
//  - Emits restart and player-count commands.
//  - Sits between ps2_keyboard and game_logic, replacing the inline decoder in the top level.

---
 rtl/tron_types.sv | 39 +++
 rtl/dir_queue.sv | 68 ++++++
 rtl/ps2_player_input.sv | 141 ++++++++++++++
 tb/tb_ps2_player_input.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_types.sv
// Shared Tron types: directions, per-player keymap, default headings and scancode constants.
package tron_types;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam int MAX_PLAYERS = 4;

   typedef struct packed {
      logic       ext;
      logic [7:0] code;
   } keymap_t;

   // Column order matches dir_t: UP, DOWN, LEFT, RIGHT.
   localparam keymap_t KEYMAP [MAX_PLAYERS][4] = '{
      '{'{1'b0, 8'h1D}, '{1'b0, 8'h1B}, '{1'b0, 8'h1C}, '{1'b0, 8'h23}},
      '{'{1'b1, 8'h75}, '{1'b1, 8'h72}, '{1'b1, 8'h6B}, '{1'b1, 8'h74}},
      '{'{1'b0, 8'h43}, '{1'b0, 8'h42}, '{1'b0, 8'h3B}, '{1'b0, 8'h4B}},
      '{'{1'b0, 8'h2C}, '{1'b0, 8'h34}, '{1'b0, 8'h2B}, '{1'b0, 8'h33}}
   };

   localparam dir_t DEFAULT_DIR [MAX_PLAYERS] = '{DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP};

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_3     = 8'h26;
   localparam logic [7:0] SC_4     = 8'h25;

   function automatic dir_t opposite(input dir_t d);
      return dir_t'({d[1], ~d[0]});
   endfunction

endpackage

// File: rtl/dir_queue.sv
// Per-player circular buffer of pending direction requests; a push into a full,
// non-popping queue replaces the tail so the newest request wins.
module dir_queue
   import tron_types::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       push,
   input  dir_t       push_dir,
   input  logic       pop,
   input  logic       clear,
   output dir_t       head,
   output dir_t       tail,
   output logic       empty,
   output logic       full,
   output logic [3:0] level
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dir_t           mem [DEPTH];
   logic [PW-1:0]  rd;
   logic [PW-1:0]  wr;
   logic [PW-1:0]  wr_prev;
   logic [3:0]     count;
   logic           do_pop;
   logic           room;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign wr_prev = (wr == '0) ? PW'(DEPTH - 1) : wr - PW'(1);
   assign empty   = (count == 4'd0);
   assign full    = (count == 4'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign room    = ~full | do_pop;
   assign head    = mem[rd];
   assign tail    = mem[wr_prev];
   assign level   = count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else if (clear) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (do_pop)
            rd <= inc(rd);
         if (push && room)
            wr <= inc(wr);
         count <= count + 4'(push & room) - 4'(do_pop);
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (push && !clear)
         mem[room ? wr : wr_prev] <= push_dir;
   end

endmodule

// File: rtl/ps2_player_input.sv
// PS/2 scancode decoder for Tron players: prefix tracking, per-player turn queues,
// restart and player-count commands. Define TRON_NO_REVERSE_EN to drop 180-degree turns.
module ps2_player_input
   import tron_types::*;
#(
   parameter int NUM_PLAYERS     = 4,
   parameter int QUEUE_DEPTH     = 2,
   parameter int DEFAULT_PLAYERS = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ps2_code_new,
   input  logic [7:0] ps2_code,
   input  logic       step,
   output dir_t       dir [NUM_PLAYERS],
   output logic [2:0] player_count,
   output logic       restart,
   output logic [3:0] q_level [NUM_PLAYERS]
);

   localparam logic [2:0] CNT_3   = 3'((NUM_PLAYERS < 3) ? NUM_PLAYERS : 3);
   localparam logic [2:0] CNT_4   = 3'((NUM_PLAYERS < 4) ? NUM_PLAYERS : 4);

   logic [1:0] hist;
   logic       stb;
   logic       ext;
   logic       brk;
   logic       decode;
   logic       cmd_hit;
   logic [2:0] cmd_count;

   logic       push_req [NUM_PLAYERS];
   dir_t       req_dir  [NUM_PLAYERS];
   logic       push_ok  [NUM_PLAYERS];
   logic       pop_ok   [NUM_PLAYERS];
   dir_t       head     [NUM_PLAYERS];
   dir_t       tail     [NUM_PLAYERS];
   dir_t       last     [NUM_PLAYERS];
   logic       empty    [NUM_PLAYERS];
   logic       full     [NUM_PLAYERS];

   assign stb    = hist[0] & ~hist[1];
   assign decode = stb & (ps2_code != SC_EXT) & (ps2_code != SC_BRK);

   always_comb begin
      cmd_hit   = 1'b0;
      cmd_count = player_count;
      if (decode && brk && !ext) begin
         case (ps2_code)
            SC_SPACE: cmd_hit = 1'b1;
            SC_2:     begin cmd_hit = 1'b1; cmd_count = 3'd2;  end
            SC_3:     begin cmd_hit = 1'b1; cmd_count = CNT_3; end
            SC_4:     begin cmd_hit = 1'b1; cmd_count = CNT_4; end
            default:  cmd_hit = 1'b0;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         push_req[i] = 1'b0;
         req_dir[i]  = DIR_UP;
         if (decode && !brk && (3'(i) < player_count)) begin
            for (int d = 0; d < 4; d++) begin
               if (KEYMAP[i][d] == {ext, ps2_code}) begin
                  push_req[i] = 1'b1;
                  req_dir[i]  = dir_t'(2'(d));
               end
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      // Duplicate filtering compares against the newest pending request, or the live heading.
      assign last[p] = (full[p] | ~empty[p]) ? tail[p] : dir[p];
`ifdef TRON_NO_REVERSE_EN
      assign push_ok[p] = push_req[p] & (req_dir[p] != last[p])
                          & (req_dir[p] != opposite(last[p]));
`else
      assign push_ok[p] = push_req[p] & (req_dir[p] != last[p]);
`endif
      assign pop_ok[p]  = step & ~cmd_hit & ~empty[p];

      dir_queue #(
         .DEPTH(QUEUE_DEPTH)
      ) u_queue (
         .clock    (clock),
         .reset_n  (reset_n),
         .push     (push_ok[p]),
         .push_dir (req_dir[p]),
         .pop      (pop_ok[p]),
         .clear    (cmd_hit),
         .head     (head[p]),
         .tail     (tail[p]),
         .empty    (empty[p]),
         .full     (full[p]),
         .level    (q_level[p])
      );
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PLAYERS; i++)
            dir[i] <= DEFAULT_DIR[i];
      end else begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (cmd_hit)
               dir[i] <= DEFAULT_DIR[i];
            else if (pop_ok[i])
               dir[i] <= head[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hist         <= 2'b00;
         ext          <= 1'b0;
         brk          <= 1'b0;
         player_count <= 3'(DEFAULT_PLAYERS);
         restart      <= 1'b0;
      end else begin
         hist    <= {hist[0], ps2_code_new};
         restart <= cmd_hit;
         if (stb) begin
            if (ps2_code == SC_EXT) begin
               ext <= 1'b1;
            end else if (ps2_code == SC_BRK) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end
         if (cmd_hit)
            player_count <= cmd_count;
      end
   end

endmodule

// File: tb/tb_ps2_player_input.sv
// Bench for ps2_player_input: queue-based reference model checked every cycle,
// plus directed scancode sequences with literal expectations.
module tb_ps2_player_input;
   import tron_types::*;

   localparam int NP = 4;
   localparam int QD = 2;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_code_new = 1'b0;
   logic [7:0] ps2_code = 8'h00;
   logic       step = 1'b0;
   dir_t       dir [NP];
   logic [2:0] player_count;
   logic       restart;
   logic [3:0] q_level [NP];

   int errors = 0;
   int checks = 0;
   int rst_pulses = 0;

   always #5 clock = ~clock;

   ps2_player_input #(
      .NUM_PLAYERS     (NP),
      .QUEUE_DEPTH     (QD),
      .DEFAULT_PLAYERS (4)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .ps2_code_new (ps2_code_new),
      .ps2_code     (ps2_code),
      .step         (step),
      .dir          (dir),
      .player_count (player_count),
      .restart      (restart),
      .q_level      (q_level)
   );

   // ---------------- reference model ----------------
   dir_t m_dir [NP];
   dir_t m_q   [NP][$];
   int   m_cnt;
   bit   m_ext, m_brk, m_restart;
   int   m_hi;

   function automatic dir_t def_dir(input int p);
      case (p)
         0: return DIR_RIGHT;
         1: return DIR_LEFT;
         2: return DIR_DOWN;
         default: return DIR_UP;
      endcase
   endfunction

   function automatic dir_t rev(input dir_t d);
      case (d)
         DIR_UP:   return DIR_DOWN;
         DIR_DOWN: return DIR_UP;
         DIR_LEFT: return DIR_RIGHT;
         default:  return DIR_LEFT;
      endcase
   endfunction

   task automatic key_lookup(input bit e, input logic [7:0] c, output int p, output dir_t d);
      p = -1;
      d = DIR_UP;
      case ({e, c})
         9'h01D: begin p = 0; d = DIR_UP;    end
         9'h01B: begin p = 0; d = DIR_DOWN;  end
         9'h01C: begin p = 0; d = DIR_LEFT;  end
         9'h023: begin p = 0; d = DIR_RIGHT; end
         9'h175: begin p = 1; d = DIR_UP;    end
         9'h172: begin p = 1; d = DIR_DOWN;  end
         9'h16B: begin p = 1; d = DIR_LEFT;  end
         9'h174: begin p = 1; d = DIR_RIGHT; end
         9'h043: begin p = 2; d = DIR_UP;    end
         9'h042: begin p = 2; d = DIR_DOWN;  end
         9'h03B: begin p = 2; d = DIR_LEFT;  end
         9'h04B: begin p = 2; d = DIR_RIGHT; end
         9'h02C: begin p = 3; d = DIR_UP;    end
         9'h034: begin p = 3; d = DIR_DOWN;  end
         9'h02B: begin p = 3; d = DIR_LEFT;  end
         9'h033: begin p = 3; d = DIR_RIGHT; end
         default: p = -1;
      endcase
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_dir[i] = def_dir(i);
         m_q[i].delete();
      end
      m_cnt = 4; m_ext = 0; m_brk = 0; m_restart = 0; m_hi = 0;
   endtask

   task automatic model_step();
      bit   rs, pend, accept;
      int   kp;
      dir_t kd, last;
      if (!reset_n) begin
         model_reset();
         return;
      end
      rs = 0; pend = 0; kp = -1; kd = DIR_UP;
      m_restart = 0;
      if (ps2_code_new) begin
         if (m_hi < 3) m_hi++;
      end else begin
         m_hi = 0;
      end
      // A byte is acted on at the second edge that sees ps2_code_new high.
      if (m_hi == 2) begin
         if (ps2_code == 8'hE0) m_ext = 1;
         else if (ps2_code == 8'hF0) m_brk = 1;
         else begin
            if (m_brk && !m_ext) begin
               case (ps2_code)
                  8'h29: rs = 1;
                  8'h1E: begin rs = 1; m_cnt = 2; end
                  8'h26: begin rs = 1; m_cnt = (NP < 3) ? NP : 3; end
                  8'h25: begin rs = 1; m_cnt = NP; end
                  default: rs = 0;
               endcase
            end else if (!m_brk) begin
               key_lookup(m_ext, ps2_code, kp, kd);
               if (kp >= 0 && kp < m_cnt) pend = 1;
            end
            m_ext = 0;
            m_brk = 0;
         end
      end
      if (rs) begin
         for (int i = 0; i < NP; i++) begin
            m_dir[i] = def_dir(i);
            m_q[i].delete();
         end
         m_restart = 1;
      end else begin
         if (step)
            for (int i = 0; i < NP; i++)
               if (m_q[i].size() > 0) m_dir[i] = m_q[i].pop_front();
         if (pend) begin
            last = (m_q[kp].size() > 0) ? m_q[kp][m_q[kp].size()-1] : m_dir[kp];
            accept = (kd != last);
`ifdef TRON_NO_REVERSE_EN
            if (kd == rev(last)) accept = 0;
`endif
            if (accept) begin
               if (m_q[kp].size() == QD) m_q[kp][QD-1] = kd;
               else m_q[kp].push_back(kd);
            end
         end
      end
   endtask

   always @(posedge clock or negedge reset_n) model_step();

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("model dir[%0d]", i), dir[i], m_dir[i]);
         chk($sformatf("model q_level[%0d]", i), q_level[i], m_q[i].size());
      end
      chk("model player_count", player_count, m_cnt);
      chk("model restart", restart, m_restart);
      if (restart) rst_pulses++;
   end

   // ---------------- stimulus ----------------
   task automatic send_byte(input logic [7:0] b);
      @(posedge clock); #1;
      ps2_code = b;
      ps2_code_new = 1'b1;
      repeat (3) @(posedge clock);
      #1 ps2_code_new = 1'b0;
      repeat (2) @(posedge clock);
   endtask

   task automatic do_step();
      @(posedge clock); #1 step = 1'b1;
      @(posedge clock); #1 step = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clock); #2 reset_n = 1'b0;
      #4 reset_n = 1'b1;
   endtask

   initial begin : stim
      int rp0;
      model_reset();
      // Reset state
      repeat (2) @(negedge clock);
      chk("reset dir0", dir[0], DIR_RIGHT);
      chk("reset dir1", dir[1], DIR_LEFT);
      chk("reset dir2", dir[2], DIR_DOWN);
      chk("reset dir3", dir[3], DIR_UP);
      chk("reset player_count", player_count, 4);
      chk("reset restart", restart, 0);
      chk("reset q_level0", q_level[0], 0);
      chk("reset q_level3", q_level[3], 0);
      @(posedge clock); #1 reset_n = 1'b1;

      // Single turn, then duplicate filtering from a fresh state
      send_byte(8'h1D);
      @(negedge clock); chk("t2 level after 1D", q_level[0], 1);
      do_step();
      @(negedge clock); chk("t2 dir0 after step", dir[0], DIR_UP);
      chk("t2 level after step", q_level[0], 0);
      pulse_reset();
      @(negedge clock); chk("t2 dir0 after reset", dir[0], DIR_RIGHT);
      repeat (3) send_byte(8'h1D);
      @(negedge clock); chk("t2 level dup drop", q_level[0], 1);

      // Full queue: newest request replaces the tail
      send_byte(8'h1C);
      send_byte(8'h1B);
      @(negedge clock); chk("t3 level full", q_level[0], 2);
      do_step();
      @(negedge clock); chk("t3 dir0 step1", dir[0], DIR_UP);
      do_step();
      @(negedge clock); chk("t3 dir0 step2", dir[0], DIR_DOWN);
      chk("t3 level drained", q_level[0], 0);

      // Extended keys and extended release
      send_byte(8'hE0); send_byte(8'h75);
      @(negedge clock); chk("t4 ext make", q_level[1], 1);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      @(negedge clock); chk("t4 ext break", q_level[1], 1);
      send_byte(8'h75);
      @(negedge clock); chk("t4 bare 75", q_level[1], 1);
      do_step();
      @(negedge clock); chk("t4 dir1", dir[1], DIR_UP);
      chk("t4 dir0 held", dir[0], DIR_DOWN);

      // Player-count command with restart
      send_byte(8'h1C);
      @(negedge clock); chk("t5 pending before restart", q_level[0], 1);
      rp0 = rst_pulses;
      send_byte(8'h26);
      @(negedge clock); chk("t5 make 26 no-op", player_count, 4);
      send_byte(8'hF0); send_byte(8'h26);
      @(negedge clock);
      chk("t5 player_count", player_count, 3);
      chk("t5 restart pulses", rst_pulses - rp0, 1);
      chk("t5 dir0 default", dir[0], DIR_RIGHT);
      chk("t5 dir1 default", dir[1], DIR_LEFT);
      chk("t5 queue cleared", q_level[0], 0);
      send_byte(8'h2C);
      @(negedge clock); chk("t5 P3 ignored", q_level[3], 0);
      send_byte(8'hF0); send_byte(8'h25);
      @(negedge clock); chk("t5 back to 4", player_count, 4);

      // Reversal
      send_byte(8'h1C);
      do_step();
      @(negedge clock);
`ifdef TRON_NO_REVERSE_EN
      chk("t6 reversal dropped", dir[0], DIR_RIGHT);
`else
      chk("t6 reversal queued", dir[0], DIR_LEFT);
`endif

      // Reset after a lone E0 clears the prefix
      pulse_reset();
      send_byte(8'hE0);
      pulse_reset();
      send_byte(8'h1D);
      @(negedge clock); chk("t6 no prefix after reset", q_level[0], 1);

      repeat (3) @(posedge clock);
      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

endmodule
